mux_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the team's 16:1 bit-select mux (built from two 8:1 muxes and a 2:1 mux) among 16 requesters. It drives the 4-bit mux select and a one-hot grant, and holds each grant until the owner releases it or a hold limit expires. It sits directly in front of the 16:1 mux, whose `select[3:0]` it owns, and behind the requesters.

---
 rtl/mux_arb_pkg.sv | 6 +
 rtl/rr_pick.sv | 24 ++
 rtl/mux_rr_arbiter.sv | 67 ++++++
 tb/tb_mux_rr_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared sizes and FSM state type for the mux round-robin arbiter
package mux_arb_pkg;
  localparam int N = 16;
  localparam int SELW = 4;
  typedef enum logic [1:0] {IDLE, GRANT, GAP} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority encoder, first set req bit at or above base with wrap
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] base,
  output logic            any,
  output logic [SELW-1:0] idx
);
  logic [SELW-1:0] j;
  // scan offsets from farthest to nearest so the nearest set bit wins
  always_comb begin
    any = 1'b0;
    idx = base;
    j = base;
    for (int i = N - 1; i >= 0; i--) begin
      j = base + SELW'(i);
      if (req[j]) begin
        any = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner of the 16:1 mux select; MUX_ARB_HOLD_LIMIT_EN enables the hold limit
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [SELW-1:0] select,
  output logic [N-1:0]    grant,
  output logic            valid,
  output logic            timeout
);
  arb_state_t state, state_n;
  logic [SELW-1:0] ptr, pick_idx;
  logic pick_any, rel, expire;
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD must be within 1..255");
  end
  rr_pick u_pick (.req(req), .base(ptr), .any(pick_any), .idx(pick_idx));
  assign rel = done || !req[select];
`ifdef MUX_ARB_HOLD_LIMIT_EN
  logic [7:0] hold_cnt;
  assign expire = hold_cnt == 8'(MAX_HOLD);
  // count cycles of the current grant, saturating at the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_cnt <= '0;
    else if (state == IDLE && pick_any) hold_cnt <= 8'd1;
    else if (state == GRANT && !rel && !expire) hold_cnt <= hold_cnt + 8'd1;
  end
`else
  assign expire = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // next state: arbitrate in IDLE, hold until release, one GAP cycle between owners
  always_comb begin
    state_n = state == IDLE  ? (pick_any ? GRANT : IDLE) :
              state == GRANT ? ((rel || expire) ? GAP : GRANT) : IDLE;
  end
  // registered outputs and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      select  <= '0;
      grant   <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
      ptr     <= '0;
    end else begin
      timeout <= state == GRANT && !rel && expire;
      if (state == IDLE && pick_any) begin
        select <= pick_idx;
        grant  <= N'(1) << pick_idx;
        valid  <= 1'b1;
      end else if (state == GRANT && (rel || expire)) begin
        grant <= '0;
        valid <= 1'b0;
        ptr   <= select + SELW'(1);
      end
    end
  end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed and random checks of the arbiter against a behavioural model
module tb_mux_rr_arbiter;
  localparam int MAXH = 8;
`ifdef MUX_ARB_HOLD_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic done = 1'b0;
  logic [15:0] req = '0;
  logic [3:0] select;
  logic [15:0] grant;
  logic valid, timeout;
  int total = 0;
  int bad = 0;
  int phase, owner, held, mptr;
  logic [3:0] e_sel;
  logic [15:0] e_grant;
  logic e_valid, e_to;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .select(select), .grant(grant), .valid(valid), .timeout(timeout)
  );

  function automatic int pick(input logic [15:0] r, input int p);
    for (int o = 0; o < 16; o++)
      if (r[(p + o) % 16]) return (p + o) % 16;
    return -1;
  endfunction

  task automatic mreset();
    phase = 0; owner = 0; held = 0; mptr = 0;
    e_sel = '0; e_grant = '0; e_valid = 1'b0; e_to = 1'b0;
  endtask

  task automatic release_owner(input bit by_limit);
    e_grant = '0; e_valid = 1'b0; e_to = by_limit;
    mptr = (owner + 1) % 16; phase = 2;
  endtask

  task automatic mstep();
    int k;
    if (rst) begin
      mreset();
      return;
    end
    e_to = 1'b0;
    if (phase == 0) begin
      k = pick(req, mptr);
      if (k >= 0) begin
        owner = k; held = 1; phase = 1;
        e_sel = 4'(k); e_grant = 16'd1 << k; e_valid = 1'b1;
      end
    end else if (phase == 1) begin
      if (done || !req[owner]) release_owner(1'b0);
      else if (LIM && held == MAXH) release_owner(1'b1);
      else held++;
    end else phase = 0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("select", {12'd0, select}, {12'd0, e_sel});
    chk("grant", grant, e_grant);
    chk("valid", {15'd0, valid}, {15'd0, e_valid});
    chk("timeout", {15'd0, timeout}, {15'd0, e_to});
  endtask

  task automatic step();
    @(posedge clk);
    mstep();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 40 && valid !== 1'b1; i++) step();
    chk("wait_valid", {15'd0, valid}, 16'd1);
  endtask

  task automatic pulse_done();
    done = 1'b1;
    step();
    done = 1'b0;
  endtask

  initial begin
    logic [3:0] rr_order [4];
    rr_order = '{4'd0, 4'd15, 4'd0, 4'd15};
    mreset();
    req = 16'hFFFF;
    steps(3);
    rst = 1'b0;
    req = 16'h0020;
    step();
    chk("single_sel", {12'd0, select}, 16'd5);
    steps(2);
    pulse_done();
    chk("single_rel", {15'd0, valid}, 16'd0);
    steps(2);
    chk("single_regrant", grant, 16'h0020);
    pulse_done();
    req = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 16'h8001;
    for (int i = 0; i < 4; i++) begin
      wait_valid();
      chk("rr_order", {12'd0, select}, {12'd0, rr_order[i]});
      pulse_done();
    end
    req = 16'h0004;
    steps(22);
    req = '0;
    steps(4);
    req = 16'h4000;
    wait_valid();
    chk("wrap_14", {12'd0, select}, 16'd14);
    pulse_done();
    req = 16'h0009;
    wait_valid();
    chk("wrap_0", {12'd0, select}, 16'd0);
    pulse_done();
    wait_valid();
    chk("skip_3", {12'd0, select}, 16'd3);
    pulse_done();
    req = 16'h0100;
    wait_valid();
    chk("mid_grant", grant, 16'h0100);
    #2 rst = 1'b1;
    #1;
    mreset();
    check_all();
    step();
    rst = 1'b0;
    req = 16'h0101;
    wait_valid();
    chk("post_rst_sel", {12'd0, select}, 16'd0);
    for (int i = 0; i < 400; i++) begin
      req = ($urandom % 4 == 0) ? 16'h0 : 16'($urandom) & 16'($urandom);
      done = ($urandom % 4 == 0);
      step();
    end
    done = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
